fifo_bank_seq: RTL and testbench
================================

# fifo_bank_seq

Sequencer for a bank of NUM_FIFOS identical FIFOs, each DEPTH entries deep with a registered read port. It accepts a single input stream and fills the FIFOs one after another: FIFO 0 receives the first DEPTH beats, FIFO 1 the next DEPTH, and so on. It then drains all FIFOs in lockstep, so every FIFO presents one entry per cycle to the downstream MAC array. It sits between the input data source and the FIFO bank and owns every FIFO write and read enable.

## Interface
- NUM_FIFOS, default 8: number of FIFOs in the bank, must be at least 2.
- DEPTH, default 8: entries per FIFO; also the number of beats written to each FIFO and the number of lockstep reads.
- DATA_WIDTH, default 8: width of the input stream and of each FIFO entry.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset; the same net resets the FIFO bank.
- start  in  1  begin one fill/drain pass; sampled only in IDLE.
- in_valid  in  1  input beat valid.
- in_data  in  DATA_WIDTH  input beat.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- fifo_wren  out  NUM_FIFOS  one-hot write enable; bit k drives FIFO k.
- fifo_wdata  out  DATA_WIDTH  shared write data, equal to in_data at all times.
- fifo_full  in  NUM_FIFOS  full flag from each FIFO.
- fifo_empty  in  NUM_FIFOS  empty flag from each FIFO.
- fifo_rden  out  NUM_FIFOS  read enable; all bits always carry the same value.
- out_valid  out  1  FIFO o_data outputs hold a fresh lockstep word.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse marking the final out_valid of a pass.

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- Internal counters:
  - sel: $clog2(NUM_FIFOS) bits, the FIFO currently being filled.
  - wcnt: beats written to FIFO sel.
  - rcnt: lockstep reads issued.
  - wcnt and rcnt are $clog2(DEPTH)+1 bits and are compared against DEPTH-1, never allowed to wrap.
- IDLE:
  - in_ready = 0, fifo_wren = 0, fifo_rden = 0.
  - start=1 moves to FILL; sel, wcnt and rcnt are cleared.
- FILL:
  - in_ready = !fifo_full[sel].
  - On an accepted beat, fifo_wren[sel] = 1 and wcnt increments.
  - When the accepted beat is the one with wcnt==DEPTH-1, wcnt clears and sel increments.
  - If that beat also has sel==NUM_FIFOS-1, the next state is DRAIN.
  - fifo_full[sel]=1 in FILL means a bank mis-size; it only stalls via in_ready and leaves the state unchanged.
- DRAIN:
  - fifo_rden = all-ones when every fifo_empty bit is 0, else all-zeros. This is a stall and has no error side effect.
  - Each issued read increments rcnt.
  - The read with rcnt==DEPTH-1 moves the state to DONE.
  - in_ready = 0.
- DONE:
  - done = 1; there is no rden.
  - Next state is IDLE unconditionally.
- out_valid is a register: next value = (state==DRAIN && reads issued this cycle).
- start is ignored outside IDLE. A start asserted in the DONE cycle is ignored; the earliest new start is the first IDLE cycle.
- Reset while in any state:
  - state becomes IDLE, and all counters and out_valid clear immediately.
  - There is no partial-pass recovery; the FIFO bank is emptied by the same reset.

## Timing
- Reset values:
  - in_ready=0, fifo_wren=0, fifo_rden=0, out_valid=0, busy=0, done=0.
  - fifo_wdata follows in_data.
- in_ready, fifo_wren and fifo_rden are combinational from state, counters and the FIFO flags. busy and done decode the state register.
- start sampled at edge t: busy=1 and in_ready can go high in cycle t+1.
- The fill takes exactly NUM_FIFOS*DEPTH accepted beats; gaps in in_valid only stretch FILL.
- If the last beat is accepted in cycle f, DRAIN begins at f+1. The last FIFO's count updates at that edge, so with no stalls rden is high in cycles f+1 … f+DEPTH.
- FIFO o_data is valid the cycle after rden, so out_valid is high in cycles f+2 … f+DEPTH+1.
- The DONE cycle is f+DEPTH+1: done=1 coincides with the last out_valid. IDLE follows at f+DEPTH+2.
- Minimum pass length with no bubbles: 1 + NUM_FIFOS*DEPTH + DEPTH + 1 cycles from start to IDLE.
- A stall in DRAIN inserts matching gaps in out_valid. Read count and data order are unchanged.

## Test plan
- Reset: hold rst_n=0 mid-clock, then release → every output at its reset value, state IDLE, busy=0.
- Continuous fill, defaults: start, then in_data=0..63 with in_valid held 1 →
  - fifo_wren walks one-hot bit 0 (beats 0-7) through bit 7 (beats 56-63).
  - After the drain, FIFO k has output 8k..8k+7 in order.
  - out_valid is high for 8 consecutive cycles, and done is high with the 8th.
- Bubbled input: in_valid toggling 1/0 for the same 64 values → identical FIFO contents; FILL takes about 128 cycles; the drain timing is unchanged.
- Protocol edges:
  - start pulsed during FILL and during DONE → no effect.
  - A second start in the first IDLE cycle → a clean second pass with the same output sequence.
- DRAIN stall: force fifo_empty[3]=1 for 3 cycles mid-drain → fifo_rden is all-zero for those 3 cycles, out_valid has a 3-cycle gap, 8 total reads still occur, and done still fires with the last word.
- Reset mid-operation: assert rst_n=0 after 20 accepted beats → busy=0 and in_ready=0 immediately. A following full pass produces the correct 0..63 mapping.

Source files
------------

// File: rtl/fifo_bank_seq.sv
// rtl/fifo_bank_seq.sv - fills a FIFO bank one FIFO at a time, then drains all FIFOs in lockstep
module fifo_bank_seq #(
    parameter int NUM_FIFOS  = 8,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [NUM_FIFOS-1:0]  fifo_wren,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic [NUM_FIFOS-1:0]  fifo_full,
    input  logic [NUM_FIFOS-1:0]  fifo_empty,
    output logic [NUM_FIFOS-1:0]  fifo_rden,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int SEL_W = $clog2(NUM_FIFOS);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_FIFOS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] r_rcnt;
    logic             r_out_valid;
    logic             w_ready;
    logic             w_accept;
    logic             w_read;
    logic             w_last_beat;

    assign w_last_beat = (r_wcnt == LAST_CNT);

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_accept = 1'b0;
        w_read   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FILL;
            end
            S_FILL: begin
                // a full FIFO here only means the bank is mis-sized; just stall
                w_ready  = !fifo_full[r_sel];
                w_accept = in_valid && w_ready;
                if (w_accept && w_last_beat && (r_sel == LAST_SEL)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_read = ~|fifo_empty;
                if (w_read && (r_rcnt == LAST_CNT)) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // FIFO read data appears one cycle after rden
            r_out_valid <= w_read;
            if ((r_state == S_IDLE) && start) begin
                r_sel  <= '0;
                r_wcnt <= '0;
                r_rcnt <= '0;
            end
            if (w_accept) begin
                if (w_last_beat) begin
                    r_wcnt <= '0;
                    if (r_sel != LAST_SEL) r_sel <= r_sel + 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
            if (w_read) r_rcnt <= r_rcnt + 1'b1;
        end
    end

    assign in_ready   = w_ready;
    assign fifo_wren  = NUM_FIFOS'(w_accept) << r_sel;
    assign fifo_wdata = in_data;
    assign fifo_rden  = {NUM_FIFOS{w_read}};
    assign out_valid  = r_out_valid;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_fifo_bank_seq.sv
// tb/tb_fifo_bank_seq.sv - randomized self-checking bench for fifo_bank_seq with a behavioural FIFO bank
module tb_fifo_bank_seq;

    localparam int NF = 8;
    localparam int D  = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [NF-1:0] fifo_wren;
    logic [DW-1:0] fifo_wdata;
    logic [NF-1:0] fifo_full;
    logic [NF-1:0] fifo_empty;
    logic [NF-1:0] fifo_rden;
    logic          out_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fifo_bank_seq #(.NUM_FIFOS(NF), .DEPTH(D), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural FIFO bank: circular buffers with a registered read port
    logic [DW-1:0] m_mem [NF][D];
    int            m_wp  [NF];
    int            m_rp  [NF];
    int            m_cnt [NF];
    logic [DW-1:0] m_odata [NF];
    logic [NF-1:0] force_empty = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NF; k++) begin
                m_wp[k]    <= 0;
                m_rp[k]    <= 0;
                m_cnt[k]   <= 0;
                m_odata[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NF; k++) begin
                if (fifo_wren[k]) begin
                    m_mem[k][m_wp[k]] <= fifo_wdata;
                    m_wp[k] <= (m_wp[k] + 1) % D;
                end
                if (fifo_rden[k]) begin
                    m_odata[k] <= m_mem[k][m_rp[k]];
                    m_rp[k] <= (m_rp[k] + 1) % D;
                end
                m_cnt[k] <= m_cnt[k] + int'(fifo_wren[k]) - int'(fifo_rden[k]);
            end
        end
    end

    always_comb begin
        fifo_full  = '0;
        fifo_empty = '0;
        for (int k = 0; k < NF; k++) begin
            fifo_full[k]  = (m_cnt[k] == D);
            fifo_empty[k] = (m_cnt[k] == 0) || force_empty[k];
        end
    end

    logic [DW-1:0] exp_d [NF*D];

    // one full pass; entered mid-cycle so start is sampled at the next edge
    task automatic run_pass(input string tag, input bit rand_data, input bit bubbles,
                            input bit do_stall, input bit poke_start);
        int beat, f, t0, reads, nout, stall_left, done_cyc, idle_cyc, budget, extra;
        bit prev_rd, exp_done;
        logic [NF-1:0] exp_wren, exp_rden;
        for (int i = 0; i < NF*D; i++) exp_d[i] = rand_data ? DW'($urandom) : DW'(i);
        beat = 0; reads = 0; nout = 0; f = -1; done_cyc = -1; idle_cyc = -1;
        stall_left = do_stall ? 3 : 0;
        extra = do_stall ? 3 : 0;
        prev_rd = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        budget = 0;
        while (beat < NF*D && budget < 1000) begin
            in_valid = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = exp_d[beat];
            start    = poke_start && (beat == 20);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b1 || fifo_rden !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s fill_flags beat %0d: busy=%b in_ready=%b rden=%b out_valid=%b, required 1 1 0 0",
                         tag, beat, busy, in_ready, fifo_rden, out_valid);
            end
            checks++;
            if (fifo_wdata !== in_data) begin
                errors++;
                $display("FAIL %s wdata: got %h required %h", tag, fifo_wdata, in_data);
            end
            exp_wren = in_valid ? (NF'(1) << (beat / D)) : '0;
            checks++;
            if (fifo_wren !== exp_wren) begin
                errors++;
                $display("FAIL %s wren beat %0d: got %b required %b", tag, beat, fifo_wren, exp_wren);
            end
            if (in_valid && in_ready) begin
                beat++;
                if (beat == NF*D) f = cyc;
            end
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if (beat != NF*D) begin
            errors++;
            $display("FAIL %s fill_timeout: accepted %0d beats, required %0d", tag, beat, NF*D);
            return;
        end
        if (!bubbles) begin
            checks++;
            if (f != t0 + NF*D - 1) begin
                errors++;
                $display("FAIL %s fill_length: last beat cycle %0d, required %0d", tag, f, t0 + NF*D - 1);
            end
        end
        budget = 0;
        while (budget < 40) begin
            force_empty = '0;
            if (stall_left > 0 && reads == 3) begin
                force_empty[3] = 1'b1;
                stall_left--;
            end
            start = poke_start && (cyc == f + D + 1 + extra);
            @(negedge clk);
            exp_rden = (reads < D && force_empty == '0) ? {NF{1'b1}} : '0;
            checks++;
            if (fifo_rden !== exp_rden) begin
                errors++;
                $display("FAIL %s rden cycle %0d: got %b required %b", tag, cyc - f, fifo_rden, exp_rden);
            end
            checks++;
            if (out_valid !== prev_rd) begin
                errors++;
                $display("FAIL %s out_valid cycle %0d: got %b required %b", tag, cyc - f, out_valid, prev_rd);
            end
            exp_done = 1'b0;
            if (out_valid === 1'b1 && nout < D) begin
                for (int k = 0; k < NF; k++) begin
                    checks++;
                    if (m_odata[k] !== exp_d[k*D + nout]) begin
                        errors++;
                        $display("FAIL %s data fifo %0d word %0d: got %h required %h",
                                 tag, k, nout, m_odata[k], exp_d[k*D + nout]);
                    end
                end
                exp_done = (nout == D - 1);
                nout++;
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b required %b", tag, cyc - f, done, exp_done);
            end
            if (done === 1'b1) done_cyc = cyc;
            if (busy !== 1'b1) begin
                idle_cyc = cyc;
                break;
            end
            prev_rd = (fifo_rden == {NF{1'b1}});
            if (prev_rd) reads++;
            @(posedge clk); #1;
            budget++;
        end
        force_empty = '0;
        start = 1'b0;
        checks++;
        if (reads != D || nout != D) begin
            errors++;
            $display("FAIL %s drain_counts: reads=%0d words=%0d, required %0d", tag, reads, nout, D);
        end
        checks++;
        if (done_cyc != f + D + 1 + extra || idle_cyc != f + D + 2 + extra) begin
            errors++;
            $display("FAIL %s drain_timing: done at f+%0d idle at f+%0d, required f+%0d and f+%0d",
                     tag, done_cyc - f, idle_cyc - f, D + 1 + extra, D + 2 + extra);
        end
        if (poke_start) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s start_in_done: busy=%b, required 0", tag, busy);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_data = DW'($urandom);
        #3;
        checks++;
        if (in_ready !== 1'b0 || fifo_wren !== '0 || fifo_rden !== '0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || fifo_wdata !== in_data) begin
            errors++;
            $display("FAIL reset_values: ready=%b wren=%b rden=%b ov=%b busy=%b done=%b wdata=%h, required all 0 and wdata=%h",
                     in_ready, fifo_wren, fifo_rden, out_valid, busy, done, fifo_wdata, in_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b in_ready=%b out_valid=%b, required 0 0 0", busy, in_ready, out_valid);
        end
    endtask

    task automatic test_continuous;
        run_pass("continuous", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_pass("back_to_back", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bubbled;
        run_pass("bubbled", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_protocol_edges;
        run_pass("protocol", 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_drain_stall;
        run_pass("drain_stall", 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int beat;
        beat = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && beat < 20; c++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) beat++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || fifo_wren !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: beats=%0d busy=%b in_ready=%b wren=%b ov=%b, required 20 0 0 0 0",
                     beat, busy, in_ready, fifo_wren, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_pass("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rst_n    = 1'b0;
        test_reset;
        test_continuous;
        test_back_to_back;
        test_bubbled;
        test_protocol_edges;
        test_drain_stall;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
